// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute/write-back unit.
//   - Default operand/address widths
//   - Opcode encoding (alu_op_e)
//   - Execute FSM state encoding (alu_state_e)
package alu_pkg;

    localparam int REG_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts a multiply)
//   start      : load a/b; bit 0 of b is consumed on the same edge
//   a, b       : multiplicand / multiplier
//   product    : low W bits of a*b, valid while done is high
//   done       : one-cycle pulse, W cycles after the start edge
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int W = REG_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  acc_q, mcand_q, mplier_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (start) begin
            // Folding bit 0 into the load edge lets the final partial sum
            // land one cycle before the caller's last EXEC cycle, so the
            // result can be registered on the way into write-back.
            acc_q    <= b[0] ? a : '0;
            mcand_q  <= a << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CW'(W - 1);
            done_q   <= (W == 1);
        end else if (cnt_q != '0) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            done_q   <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential execute/write-back stage between register file read and write
// ports. Accepts one instruction per handshake (IDLE only), fetches operands,
// computes (single cycle, or REG_WIDTH cycles for MUL) and writes back.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   instr_valid/instr_ready         : instruction handshake
//   instr_op/rd/rs1/rs2             : opcode, destination, sources
//   read_1_addr/read_2_addr         : register file read addresses
//   read_bus_1/read_bus_2           : combinational register file read data
//   write_addr/write_bus            : registered write-back address/data
//   write_enabled, done             : one-cycle write-back strobe
//   busy                            : unit not in IDLE
//   flag_zero, flag_carry           : status of last completed instruction
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [ADDR_WIDTH-1:0] instr_rd,
    input  logic [ADDR_WIDTH-1:0] instr_rs1,
    input  logic [ADDR_WIDTH-1:0] instr_rs2,
    output logic [ADDR_WIDTH-1:0] read_1_addr,
    output logic [ADDR_WIDTH-1:0] read_2_addr,
    input  logic [REG_WIDTH-1:0]  read_bus_1,
    input  logic [REG_WIDTH-1:0]  read_bus_2,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [REG_WIDTH-1:0]  write_bus,
    output logic                  write_enabled,
    output logic                  done,
    output logic                  busy,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    alu_state_e            state_q;
    alu_op_e               op_q;
    logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q, wr_addr_q;
    logic [REG_WIDTH-1:0]  opa_q, opb_q, wr_bus_q;
    logic                  carry_q, fz_q, fc_q;

    logic [REG_WIDTH-1:0]  res_d;
    logic                  carry_d;
    logic [REG_WIDTH:0]    sum;
    logic [REG_WIDTH-1:0]  mul_product;
    logic                  mul_done, mul_start;

    // Multiplier loads straight from the read buses on the FETCH edge,
    // in parallel with the operand registers.
    assign mul_start = (state_q == FETCH) && (op_q == OP_MUL);

    alu_mul_seq #(.W(REG_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (read_bus_1),
        .b       (read_bus_2),
        .product (mul_product),
        .done    (mul_done)
    );

    assign sum = {1'b0, opa_q} + {1'b0, opb_q};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (op_q)
            OP_ADD: begin res_d = sum[REG_WIDTH-1:0]; carry_d = sum[REG_WIDTH]; end
            OP_SUB: begin res_d = opa_q - opb_q;      carry_d = (opa_q < opb_q); end
            OP_AND: res_d = opa_q & opb_q;
            OP_OR:  res_d = opa_q | opb_q;
            OP_XOR: res_d = opa_q ^ opb_q;
            OP_SHL: res_d = opa_q << opb_q[3:0];
            OP_SHR: res_d = opa_q >> opb_q[3:0];
            OP_MUL: res_d = mul_product;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            wr_addr_q <= '0;
            wr_bus_q  <= '0;
            carry_q   <= 1'b0;
            fz_q      <= 1'b0;
            fc_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (instr_valid) begin
                    op_q    <= alu_op_e'(instr_op);
                    rd_q    <= instr_rd;
                    rs1_q   <= instr_rs1;
                    rs2_q   <= instr_rs2;
                    state_q <= FETCH;
                end
                FETCH: begin
                    opa_q   <= read_bus_1;
                    opb_q   <= read_bus_2;
                    state_q <= EXEC;
                end
                EXEC: if (op_q != OP_MUL || mul_done) begin
                    wr_addr_q <= rd_q;
                    wr_bus_q  <= res_d;
                    carry_q   <= carry_d;
                    state_q   <= WB;
                end
                WB: begin
                    // Flags commit with the register file write.
                    fz_q    <= (wr_bus_q == '0);
                    fc_q    <= carry_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready   = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign write_enabled = (state_q == WB);
    assign done          = (state_q == WB);
    assign write_addr    = wr_addr_q;
    assign write_bus     = wr_bus_q;
    assign read_1_addr   = rs1_q;
    assign read_2_addr   = rs2_q;
    assign flag_zero     = fz_q;
    assign flag_carry    = fc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = 3'd0;
    logic [2:0]  instr_rd = 3'd0, instr_rs1 = 3'd0, instr_rs2 = 3'd0;
    logic [2:0]  read_1_addr, read_2_addr, write_addr;
    logic [15:0] read_bus_1, read_bus_2, write_bus;
    logic        write_enabled, done, busy, flag_zero, flag_carry;

    always #5 clk = ~clk;

    alu_exec_unit #(.REG_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .read_1_addr(read_1_addr), .read_2_addr(read_2_addr),
        .read_bus_1(read_bus_1), .read_bus_2(read_bus_2),
        .write_addr(write_addr), .write_bus(write_bus),
        .write_enabled(write_enabled), .done(done), .busy(busy),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    // Behavioural register file
    logic [15:0] rf [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [15:0] pl_data = 16'd0;
    assign read_bus_1 = rf[read_1_addr];
    assign read_bus_2 = rf[read_2_addr];
    always @(posedge clk) begin
        if (write_enabled) rf[write_addr] <= write_bus;
        else if (pl_en)    rf[pl_addr]    <= pl_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Monitor: pops one expectation per write strobe, checks flags next cycle
    logic flag_pend = 1'b0;
    logic pz = 1'b0, pc = 1'b0;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (flag_pend) begin
            chk("flag_zero", flag_zero, pz);
            chk("flag_carry", flag_carry, pc);
            flag_pend = 1'b0;
        end
        if (write_enabled || done) begin
            chk("done_eq_we", done, write_enabled);
            chk("we_single_cycle", prev_we, 1'b0);
        end
        if (write_enabled) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", write_addr, 3'd0);
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", write_addr, write_bus);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", write_addr, e.addr);
                chk("write_bus", write_bus, e.data);
                chk("write_cycle", cyc, e.cyc);
                pz = e.z;
                pc = e.c;
                flag_pend = 1'b1;
            end
        end
        prev_we = write_enabled;
    end

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, instr_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_we"}, write_enabled, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_waddr"}, write_addr, 3'd0);
        chk({tag, "_wbus"}, write_bus, 16'd0);
        chk({tag, "_r1addr"}, read_1_addr, 3'd0);
        chk({tag, "_r2addr"}, read_2_addr, 3'd0);
        chk({tag, "_fz"}, flag_zero, 1'b0);
        chk({tag, "_fc"}, flag_carry, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle ready reappears.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] d, input logic z,
                         input logic c, input int lat, input bit hold);
        int n = 0;
        int bad = 0;
        int hs;
        exp_t e;
        while (!instr_ready && n < 100) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            chk("ready_timeout", instr_ready, 1'b1);
            return;
        end
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        hs = cyc;
        e.addr = rd; e.data = d; e.z = z; e.c = c; e.cyc = hs + lat;
        sb.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    instr_op = 3'd0; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
                end else instr_valid = 1'b0;
            end
            if (k <= lat) begin
                if (!busy || instr_ready) bad++;
            end else begin
                instr_valid = 1'b0;
                chk("ready_back", instr_ready, 1'b1);
                chk("busy_clear", busy, 1'b0);
            end
        end
        chk("busy_window_bad_cycles", bad, 0);
    endtask

    initial begin
        int hs;
        // Reset
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // ADD with carry out to zero
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        issue(3'b000, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, 3, 1'b0);

        // SUB with borrow, rd == rs1
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0007);
        issue(3'b001, 3'd1, 3'd1, 3'd2, 16'hFFFE, 1'b0, 1'b1, 3, 1'b0);

        // MUL with valid held during busy
        preload(3'd4, 16'h0123);
        preload(3'd5, 16'h0010);
        issue(3'b111, 3'd6, 3'd4, 3'd5, 16'h1230, 1'b0, 1'b0, 18, 1'b1);

        // Shifts and logic
        preload(3'd2, 16'h8001);
        preload(3'd7, 16'h0014);
        issue(3'b101, 3'd0, 3'd2, 3'd7, 16'h0010, 1'b0, 1'b0, 3, 1'b0);
        issue(3'b110, 3'd5, 3'd2, 3'd7, 16'h0800, 1'b0, 1'b0, 3, 1'b0);
        issue(3'b011, 3'd3, 3'd2, 3'd7, 16'h8015, 1'b0, 1'b0, 3, 1'b0);
        issue(3'b010, 3'd3, 3'd2, 3'd7, 16'h0000, 1'b1, 1'b0, 3, 1'b0);

        // Reset during MUL EXEC cycle 9: no write, everything back to reset values
        instr_valid = 1'b1; instr_op = 3'b111; instr_rd = 3'd6; instr_rs1 = 3'd4; instr_rs2 = 3'd5;
        hs = cyc;
        @(negedge clk);
        instr_valid = 1'b0;
        while (cyc < hs + 9) @(negedge clk);
        chk("mul_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midmul_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1'b1);
        // R1=FFFE (from SUB), R2=8001
        issue(3'b000, 3'd3, 3'd1, 3'd2, 16'h7FFF, 1'b0, 1'b1, 3, 1'b0);

        // Back-to-back dependency through R3
        preload(3'd1, 16'h1234);
        preload(3'd2, 16'h0F0F);
        issue(3'b000, 3'd3, 3'd1, 3'd2, 16'h2143, 1'b0, 1'b0, 3, 1'b0);
        issue(3'b100, 3'd4, 3'd3, 3'd1, 16'h3377, 1'b0, 1'b0, 3, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
